// File: rtl/awg_ctrl_pkg.sv
// ============================================================================
// Module      : awg_ctrl_pkg
// Description : Shared menu encoding, waveform codes and field limits for the
//               signal-generator front-panel controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package awg_ctrl_pkg;

    typedef enum logic [1:0] {
        MENU_WAVE  = 2'd0,
        MENU_FREQ  = 2'd1,
        MENU_AMP   = 2'd2,
        MENU_PHASE = 2'd3
    } menu_t;

    localparam logic [2:0] WAVE_SAW    = 3'd0;
    localparam logic [2:0] WAVE_TRI    = 3'd1;
    localparam logic [2:0] WAVE_SQUARE = 3'd2;
    localparam logic [2:0] WAVE_SINE   = 3'd3;
    localparam logic [2:0] WAVE_NOISE  = 3'd4;
    localparam logic [2:0] WAVE_OFF    = 3'd7;

    localparam logic [3:0] FREQ_MIN  = 4'd1;
    localparam logic [3:0] FREQ_MAX  = 4'd6;
    localparam logic [3:0] AMP_MAX   = 4'd15;
    localparam logic [2:0] PHASE_MAX = 3'd7;

    function automatic menu_t next_menu(input menu_t m);
        return menu_t'(m + 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/awg_ctrl_key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser and counter debounce for one active-low
//               key; emits the debounced level and a one-cycle press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_press;
    logic               w_raw_pressed;

    assign w_raw_pressed = ~r_sync[1];

    // The counter only runs while the synchronised level disagrees with the
    // debounced one, so any bounce back restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_press <= 1'b0;
            if (w_raw_pressed == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= w_raw_pressed;
                r_press <= w_raw_pressed;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/awg_ctrl.sv
// ============================================================================
// Module      : awg_ctrl
// Description : Front-panel controller: key debounce, auto-repeat, menu FSM and
//               registered waveform/frequency/amplitude/phase selectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module awg_ctrl #(
    parameter int DEB_CYCLES   = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_sel_n,
    input  logic        key_up_n,
    input  logic        key_dn_n,
    input  logic        key_off_n,
    output logic [2:0]  state,
    output logic [11:0] state_freq,
    output logic [3:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  menu_sel,
    output logic        cfg_stb
);

    import awg_ctrl_pkg::*;

    localparam int c_k_sel = 0;
    localparam int c_k_up  = 1;
    localparam int c_k_dn  = 2;
    localparam int c_k_off = 3;

    localparam int c_rep_w = $clog2(REPEAT_DELAY + 1);
    localparam logic [c_rep_w-1:0] c_rep_fire   = c_rep_w'(REPEAT_DELAY);
    localparam logic [c_rep_w-1:0] c_rep_rewind = c_rep_w'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic [3:0] w_key_n;
    logic [3:0] w_level;
    logic [3:0] w_press;
    logic [1:0] w_rep;
    logic       w_up;
    logic       w_dn;
    logic       w_unused_levels;

    assign w_key_n = {key_off_n, key_dn_n, key_up_n, key_sel_n};

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_key_debounce (
            .clk   (clk),
            .rst   (rst),
            .key_n (w_key_n[k]),
            .level (w_level[k]),
            .press (w_press[k])
        );
    end

    assign w_unused_levels = &{1'b0, w_level[c_k_sel], w_level[c_k_off]};

    // Hold counter reads 0 in the press cycle; after firing at REPEAT_DELAY it
    // rewinds so the next fire lands exactly REPEAT_RATE cycles later.
    for (genvar g = 0; g < 2; g++) begin : g_repeat
        logic [c_rep_w-1:0] r_hold;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hold <= '0;
            end else if (!w_level[g+1]) begin
                r_hold <= '0;
            end else if (r_hold == c_rep_fire) begin
                r_hold <= c_rep_rewind;
            end else begin
                r_hold <= r_hold + c_rep_w'(1);
            end
        end

        assign w_rep[g] = w_level[g+1] && (r_hold == c_rep_fire);
    end

    assign w_up = w_press[c_k_up] | w_rep[0];
    assign w_dn = w_press[c_k_dn] | w_rep[1];

    menu_t      r_menu;
    logic [2:0] r_wave;
    logic [2:0] r_saved;
    logic [3:0] r_freq;
    logic [3:0] r_amp;
    logic [2:0] r_phase;
    logic       r_stb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_menu  <= MENU_WAVE;
            r_wave  <= WAVE_SAW;
            r_saved <= WAVE_SAW;
            r_freq  <= FREQ_MIN;
            r_amp   <= AMP_MAX;
            r_phase <= '0;
            r_stb   <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            if (w_press[c_k_off]) begin
                if (r_wave != WAVE_OFF) begin
                    r_saved <= r_wave;
                    r_wave  <= WAVE_OFF;
                end else begin
                    r_wave <= r_saved;
                end
                r_stb <= 1'b1;
            end else if (w_press[c_k_sel]) begin
                r_menu <= next_menu(r_menu);
            end else if (w_up ^ w_dn) begin
                case (r_menu)
                    MENU_WAVE: begin
                        if (r_wave != WAVE_OFF) begin
                            if (w_up) begin
                                r_wave <= (r_wave == WAVE_NOISE) ? WAVE_SAW : r_wave + 3'd1;
                            end else begin
                                r_wave <= (r_wave == WAVE_SAW) ? WAVE_NOISE : r_wave - 3'd1;
                            end
                            r_stb <= 1'b1;
                        end
                    end
                    MENU_FREQ: begin
                        if (w_up) begin
                            r_freq <= (r_freq == FREQ_MAX) ? FREQ_MIN : r_freq + 4'd1;
                        end else begin
                            r_freq <= (r_freq == FREQ_MIN) ? FREQ_MAX : r_freq - 4'd1;
                        end
                        r_stb <= 1'b1;
                    end
                    MENU_AMP: begin
                        if (w_up && (r_amp != AMP_MAX)) begin
                            r_amp <= r_amp + 4'd1;
                            r_stb <= 1'b1;
                        end else if (w_dn && (r_amp != 4'd0)) begin
                            r_amp <= r_amp - 4'd1;
                            r_stb <= 1'b1;
                        end
                    end
                    MENU_PHASE: begin
                        if (w_up) begin
                            r_phase <= (r_phase == PHASE_MAX) ? 3'd0 : r_phase + 3'd1;
                        end else begin
                            r_phase <= (r_phase == 3'd0) ? PHASE_MAX : r_phase - 3'd1;
                        end
                        r_stb <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign state       = r_wave;
    assign state_freq  = {8'd0, r_freq};
    assign state_amp   = r_amp;
    assign state_phase = {5'd0, r_phase};
    assign menu_sel    = r_menu;
    assign cfg_stb     = r_stb;

endmodule

`default_nettype wire

// File: tb/tb_awg_ctrl.sv
// ============================================================================
// Module      : tb_awg_ctrl
// Description : Randomised scoreboard bench for awg_ctrl with a behavioural
//               front-panel model; a monitor checks every cfg_stb and idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_awg_ctrl;

    localparam int DEB  = 4;
    localparam int DLY  = 16;
    localparam int RATE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_sel_n = 1'b1;
    logic        key_up_n  = 1'b1;
    logic        key_dn_n  = 1'b1;
    logic        key_off_n = 1'b1;
    logic [2:0]  state;
    logic [11:0] state_freq;
    logic [3:0]  state_amp;
    logic [7:0]  state_phase;
    logic [1:0]  menu_sel;
    logic        cfg_stb;

    awg_ctrl #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_sel_n   (key_sel_n),
        .key_up_n    (key_up_n),
        .key_dn_n    (key_dn_n),
        .key_off_n   (key_off_n),
        .state       (state),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .menu_sel    (menu_sel),
        .cfg_stb     (cfg_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wave;
        int freq;
        int amp;
        int phase;
    } cfg_t;

    cfg_t exp_q[$];
    int   stamp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    // Behavioural model of the panel
    int m_wave, m_saved, m_freq, m_amp, m_phase, m_menu;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endfunction

    function automatic int pack(input cfg_t c);
        return (c.wave << 24) | (c.freq << 12) | (c.amp << 8) | c.phase;
    endfunction

    function automatic void model_reset();
        m_wave = 0; m_saved = 0; m_freq = 1; m_amp = 15; m_phase = 0; m_menu = 0;
        exp_q.delete();
    endfunction

    function automatic void push_cfg();
        cfg_t c;
        c = '{m_wave, m_freq, m_amp, m_phase};
        exp_q.push_back(c);
    endfunction

    function automatic void model_edit(input bit up);
        case (m_menu)
            0: if (m_wave != 7) begin
                   m_wave = up ? (m_wave + 1) % 5 : (m_wave + 4) % 5;
                   push_cfg();
               end
            1: begin
                   m_freq = up ? (m_freq % 6) + 1 : ((m_freq + 4) % 6) + 1;
                   push_cfg();
               end
            2: if (up && m_amp < 15) begin
                   m_amp++;
                   push_cfg();
               end else if (!up && m_amp > 0) begin
                   m_amp--;
                   push_cfg();
               end
            default: begin
                   m_phase = up ? (m_phase + 1) % 8 : (m_phase + 7) % 8;
                   push_cfg();
               end
        endcase
    endfunction

    // A key held low for len cycles stays debounced-pressed for len cycles:
    // one press plus repeats at DLY, DLY+RATE, ... strictly before len.
    function automatic void model_press(input bit s, input bit u, input bit d,
                                        input bit o, input int len);
        int n;
        if (o) begin
            if (m_wave != 7) begin
                m_saved = m_wave;
                m_wave  = 7;
            end else begin
                m_wave = m_saved;
            end
            push_cfg();
        end else if (s) begin
            m_menu = (m_menu + 1) % 4;
        end else if (u != d) begin
            n = 1 + ((len > DLY) ? (len - 1 - DLY) / RATE + 1 : 0);
            for (int i = 0; i < n; i++) model_edit(u);
        end
    endfunction

    task automatic act(input bit s, input bit u, input bit d, input bit o, input int len);
        @(posedge clk); #1;
        key_sel_n = !s; key_up_n = !u; key_dn_n = !d; key_off_n = !o;
        model_press(s, u, d, o, len);
        repeat (len) @(posedge clk);
        #1;
        key_sel_n = 1'b1; key_up_n = 1'b1; key_dn_n = 1'b1; key_off_n = 1'b1;
        repeat (DEB + 8) @(posedge clk);
        #1;
        check("menu_sel", int'(menu_sel), m_menu);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_freq"},  int'(state_freq), 1);
        check({tag, "_amp"},   int'(state_amp), 15);
        check({tag, "_phase"}, int'(state_phase), 0);
        check({tag, "_menu"},  int'(menu_sel), 0);
        check({tag, "_stb"},   int'(cfg_stb), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops one expectation per strobe; outputs must hold otherwise.
    initial begin
        cfg_t rc, e;
        int   cur;
        rc = '{0, 1, 15, 0};
        forever begin
            @(negedge clk);
            cur = int'({state, state_freq, state_amp, state_phase});
            if (rst) begin
                rc = '{0, 1, 15, 0};
            end else if (cfg_stb) begin
                stamp_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL cfg_stb: strobe with no expected change, outputs %0d/%0d/%0d/%0d (t=%0t)",
                             state, state_freq, state_amp, state_phase, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("stb_state", int'(state), e.wave);
                    check("stb_freq",  int'(state_freq), e.freq);
                    check("stb_amp",   int'(state_amp), e.amp);
                    check("stb_phase", int'(state_phase), e.phase);
                    rc = e;
                end
            end else begin
                check("stable_cfg", cur, pack(rc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        int r;
        int len;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");

        // Wave stepping and glitch rejection
        repeat (3) act(0, 1, 0, 0, 6);
        check("wave_after_3_up", int'(state), 3);
        @(posedge clk); #1;
        key_up_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        key_up_n = 1'b1;
        repeat (DEB + 8) @(posedge clk);
        #1;
        check("glitch_state", int'(state), 3);

        // Frequency auto-repeat timing
        act(1, 0, 0, 0, 6);
        stamp_q.delete();
        act(0, 1, 0, 0, 40);
        check("repeat_count", stamp_q.size(), 7);
        for (int i = 1; i < stamp_q.size(); i++)
            check("repeat_gap", stamp_q[i] - stamp_q[i-1], (i == 1) ? DLY : RATE);
        check("freq_after_hold", int'(state_freq), 2);

        // Amplitude saturation
        act(1, 0, 0, 0, 6);
        act(0, 1, 0, 0, 6);
        for (int i = 0; i < 16; i++) act(0, 0, 1, 0, 6);
        check("amp_floor", int'(state_amp), 0);

        // Phase wrap
        act(1, 0, 0, 0, 6);
        act(0, 0, 1, 0, 6);
        check("phase_wrap_down", int'(state_phase), 7);
        act(0, 1, 0, 0, 6);
        check("phase_wrap_up", int'(state_phase), 0);

        // Output-off toggle
        act(1, 0, 0, 0, 6);
        act(0, 0, 0, 1, 6);
        check("off_state", int'(state), 7);
        act(0, 1, 0, 0, 6);
        act(0, 0, 1, 0, 6);
        act(0, 0, 0, 1, 6);
        check("restored_state", int'(state), 3);

        // Randomised mix including simultaneous keys
        for (int k = 0; k < 30; k++) begin
            r   = $urandom_range(0, 9);
            len = $urandom_range(DEB + 1, 12);
            case (r)
                0, 1: act(1, 0, 0, 0, len);
                2, 3: act(0, 1, 0, 0, len);
                4, 5: act(0, 0, 1, 0, len);
                6:    act(0, 0, 0, 1, len);
                7:    act(0, 1, 1, 0, len);
                8:    act($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 1, len);
                default: begin
                    len = $urandom_range(DLY + 1, 40);
                    if ($urandom_range(0, 1) == 1) act(0, 1, 0, 0, len);
                    else                           act(0, 0, 1, 0, len);
                end
            endcase
        end

        // Reset mid-hold, then key still held across reset release
        @(posedge clk); #1;
        key_up_n = 1'b0;
        model_press(0, 1, 0, 0, 1);
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("queue_before_reset", exp_q.size(), 0);
        check_reset_values("async_reset");
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc;
        stamp_q.delete();
        model_press(0, 1, 0, 0, 1);
        repeat (12) @(posedge clk);
        #1;
        key_up_n = 1'b1;
        repeat (DEB + 8) @(posedge clk);
        #1;
        check("held_through_reset_latency", (stamp_q.size() > 0) ? stamp_q[0] - t0 : -1, DEB + 3);
        check("held_through_reset_state", int'(state), 1);

        // Reset mid-debounce leaves no pending press
        @(posedge clk); #1;
        key_dn_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_debounce_reset_state", int'(state), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        key_dn_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (DEB + 10) @(posedge clk);
        #1;
        check_reset_values("post_debounce_reset");

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
